// File: rtl/fw_msg_collector.sv
// Firmware message collector: edge-detected message strobes are queued by priority,
// and the NUL-terminated byte string in a local buffer is drained into a held message.
module fw_msg_collector #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IDX_W = $clog2(DEPTH),
    parameter int unsigned DW    = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 new_report,
    input  logic                 new_warning,
    input  logic                 new_error,
    input  logic                 new_compare,
    input  logic                 write_mem,
    input  logic [IDX_W-1:0]     index,
    input  logic [7:0]           data,
    input  logic [DW-1:0]        expected_reg,
    input  logic [DW-1:0]        measured_reg,
    input  logic                 msg_ack,
    output logic                 msg_valid,
    output logic [1:0]           msg_type,
    output logic [IDX_W:0]       msg_len,
    output logic [8*DEPTH-1:0]   msg_string,
    output logic [DW-1:0]        msg_expected,
    output logic [DW-1:0]        msg_measured,
    output logic                 cmp_pass,
    output logic                 busy,
    output logic                 req_overflow,
    output logic                 wr_drop,
    output logic [CNT_W-1:0]     warning_count,
    output logic [CNT_W-1:0]     error_count,
    output logic [CNT_W-1:0]     cmp_fail_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state;
    logic [3:0]       strb;
    logic [3:0]       prev;
    logic [3:0]       req;
    logic [3:0]       pending;
    logic [3:0]       clr;
    logic [1:0]       sel_type;
    logic [3:0]       sel_mask;
    logic [7:0]       mem [DEPTH];
    logic [IDX_W-1:0] ptr;
    logic [7:0]       byte_rd;
    logic             enter_done;
    logic             pass_now;

    // Bit position of each strobe equals its message type code.
    assign strb    = {new_compare, new_error, new_warning, new_report};
    assign req     = strb & ~prev;
    assign byte_rd = mem[ptr];
    assign busy    = (state != IDLE);

    always_comb begin
        sel_type = 2'd0;
        sel_mask = '0;
        if (pending[2]) begin
            sel_type = 2'd2;
            sel_mask = 4'b0100;
        end else if (pending[3]) begin
            sel_type = 2'd3;
            sel_mask = 4'b1000;
        end else if (pending[1]) begin
            sel_type = 2'd1;
            sel_mask = 4'b0010;
        end else if (pending[0]) begin
            sel_type = 2'd0;
            sel_mask = 4'b0001;
        end
    end

    always_comb begin
        clr        = (state == IDLE) ? sel_mask : '0;
        enter_done = (state == SCAN) &&
                     ((byte_rd == 8'h00) || (ptr == IDX_W'(DEPTH - 1)));
        pass_now   = (msg_type != 2'd3) || (msg_expected == msg_measured);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state          <= IDLE;
            prev           <= '0;
            pending        <= '0;
            ptr            <= '0;
            msg_valid      <= 1'b0;
            msg_type       <= '0;
            msg_len        <= '0;
            msg_string     <= '0;
            msg_expected   <= '0;
            msg_measured   <= '0;
            cmp_pass       <= 1'b0;
            req_overflow   <= 1'b0;
            wr_drop        <= 1'b0;
            warning_count  <= '0;
            error_count    <= '0;
            cmp_fail_count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[IDX_W'(i)] <= '0;
            end
        end else begin
            prev         <= strb;
            pending      <= (pending & ~clr) | req;
            req_overflow <= req_overflow | (|(req & pending));

            if (write_mem) begin
                if (state == SCAN) begin
                    wr_drop <= 1'b1;
                end else begin
                    mem[index] <= data;
                end
            end

            case (state)
                IDLE: begin
                    if (|pending) begin
                        state        <= SCAN;
                        msg_type     <= sel_type;
                        msg_expected <= expected_reg;
                        msg_measured <= measured_reg;
                        msg_string   <= '0;
                        msg_len      <= '0;
                        ptr          <= '0;
                    end
                end
                SCAN: begin
                    if (byte_rd != 8'h00) begin
                        msg_string <= {msg_string[8*DEPTH-9:0], byte_rd};
                        mem[ptr]   <= '0;
                        ptr        <= ptr + 1'b1;
                        msg_len    <= msg_len + 1'b1;
                    end
                    if (enter_done) begin
                        state     <= DONE;
                        msg_valid <= 1'b1;
                        cmp_pass  <= pass_now;
                        if (msg_type == 2'd1 && warning_count != '1)
                            warning_count <= warning_count + 1'b1;
                        if (msg_type == 2'd2 && error_count != '1)
                            error_count <= error_count + 1'b1;
                        if (!pass_now && cmp_fail_count != '1)
                            cmp_fail_count <= cmp_fail_count + 1'b1;
                    end
                end
                DONE: begin
                    if (msg_ack) begin
                        state     <= IDLE;
                        msg_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fw_msg_collector.sv
// Bench for fw_msg_collector: directed stimulus pushes hand-computed messages into a
// scoreboard queue; a monitor pops and compares each message as msg_valid rises.
module tb_fw_msg_collector;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned SW    = 8 * DEPTH;

    logic             clk;
    logic             rst;
    logic [3:0]       strb;
    logic             write_mem;
    logic [IDX_W-1:0] index;
    logic [7:0]       data;
    logic [DW-1:0]    expected_reg;
    logic [DW-1:0]    measured_reg;
    logic             msg_ack;
    logic             msg_valid;
    logic [1:0]       msg_type;
    logic [IDX_W:0]   msg_len;
    logic [SW-1:0]    msg_string;
    logic [DW-1:0]    msg_expected;
    logic [DW-1:0]    msg_measured;
    logic             cmp_pass;
    logic             busy;
    logic             req_overflow;
    logic             wr_drop;
    logic [CNT_W-1:0] warning_count;
    logic [CNT_W-1:0] error_count;
    logic [CNT_W-1:0] cmp_fail_count;

    fw_msg_collector #(
        .DEPTH(DEPTH),
        .IDX_W(IDX_W),
        .DW(DW),
        .CNT_W(CNT_W)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .new_report(strb[0]),
        .new_warning(strb[1]),
        .new_error(strb[2]),
        .new_compare(strb[3]),
        .write_mem(write_mem),
        .index(index),
        .data(data),
        .expected_reg(expected_reg),
        .measured_reg(measured_reg),
        .msg_ack(msg_ack),
        .msg_valid(msg_valid),
        .msg_type(msg_type),
        .msg_len(msg_len),
        .msg_string(msg_string),
        .msg_expected(msg_expected),
        .msg_measured(msg_measured),
        .cmp_pass(cmp_pass),
        .busy(busy),
        .req_overflow(req_overflow),
        .wr_drop(wr_drop),
        .warning_count(warning_count),
        .error_count(error_count),
        .cmp_fail_count(cmp_fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]     t;
        logic [IDX_W:0] len;
        logic [SW-1:0]  str;
        logic [DW-1:0]  e;
        logic [DW-1:0]  m;
        logic           pass;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: one pop per message, re-armed when msg_valid drops.
    initial begin : monitor
        bit   seen;
        exp_t x;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            if (msg_valid && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected message", 1, 0);
                end else begin
                    x = sb.pop_front();
                    chk("msg_type", msg_type, x.t);
                    chk("msg_len", msg_len, x.len);
                    chk("msg_string", msg_string, x.str);
                    chk("msg_expected", msg_expected, x.e);
                    chk("msg_measured", msg_measured, x.m);
                    chk("cmp_pass", cmp_pass, x.pass);
                end
            end else if (!msg_valid) begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wr(input int unsigned idx, input logic [7:0] d);
        @(negedge clk);
        write_mem = 1'b1;
        index     = IDX_W'(idx);
        data      = d;
        @(negedge clk);
        write_mem = 1'b0;
    endtask

    task automatic push(input logic [1:0] t, input int unsigned len, input logic [SW-1:0] s,
                        input logic pass);
        exp_t x;
        x.t    = t;
        x.len  = (IDX_W + 1)'(len);
        x.str  = s;
        x.e    = expected_reg;
        x.m    = measured_reg;
        x.pass = pass;
        sb.push_back(x);
    endtask

    task automatic pulse(input logic [3:0] m);
        @(negedge clk);
        strb = m;
        @(negedge clk);
        strb = '0;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!msg_valid && edges < 200) begin
            @(negedge clk);
            edges++;
        end
        if (!msg_valid) chk("msg_valid timeout", 0, 1);
    endtask

    task automatic ack();
        @(negedge clk);
        msg_ack = 1'b1;
        @(negedge clk);
        msg_ack = 1'b0;
        chk("msg_valid after ack", msg_valid, 0);
    endtask

    int n;
    int e;

    initial begin
        rst = 1'b0; strb = '0; write_mem = 1'b0; index = '0; data = '0;
        expected_reg = '0; measured_reg = '0; msg_ack = 1'b0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset msg_valid", msg_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset msg_len", msg_len, 0);
        chk("reset cmp_pass", cmp_pass, 0);
        chk("reset req_overflow", req_overflow, 0);
        chk("reset wr_drop", wr_drop, 0);
        chk("reset warning_count", warning_count, 0);
        chk("reset error_count", error_count, 0);
        rst = 1'b0;

        // "OK\0" report, then an empty report proves bytes 0..1 were cleared.
        wr(0, 8'h4F); wr(1, 8'h4B); wr(2, 8'h00);
        push(2'd0, 2, 'h4F4B, 1'b1);
        pulse(4'b0001);
        wait_valid(e);
        chk("report latency", e, 4);
        ack();
        push(2'd0, 0, '0, 1'b1);
        pulse(4'b0001);
        wait_valid(e);
        chk("empty report latency", e, 2);
        ack();

        // Compare mismatch then match.
        wr(0, 8'h43); wr(1, 8'h4D); wr(2, 8'h50); wr(3, 8'h00);
        expected_reg = 32'h5; measured_reg = 32'h6;
        push(2'd3, 3, 'h434D50, 1'b0);
        pulse(4'b1000);
        wait_valid(e);
        chk("cmp_fail_count after mismatch", cmp_fail_count, 1);
        ack();
        wr(0, 8'h43); wr(1, 8'h4D); wr(2, 8'h50); wr(3, 8'h00);
        measured_reg = 32'h5;
        push(2'd3, 3, 'h434D50, 1'b1);
        pulse(4'b1000);
        wait_valid(e);
        chk("cmp_fail_count after match", cmp_fail_count, 1);
        ack();

        // Simultaneous error and report: error first.
        wr(0, 8'h45); wr(1, 8'h00);
        push(2'd2, 1, 'h45, 1'b1);
        push(2'd0, 0, '0, 1'b1);
        pulse(4'b0101);
        wait_valid(e);
        ack();
        wait_valid(e);
        ack();
        chk("error_count", error_count, 1);
        chk("warning_count untouched", warning_count, 0);

        // Full buffer, no wrap; write during SCAN is dropped.
        for (int unsigned i = 0; i < DEPTH; i++) wr(i, 8'(i + 1));
        push(2'd0, DEPTH, 128'h0102030405060708090A0B0C0D0E0F10, 1'b1);
        pulse(4'b0001);
        n = 0;
        repeat (4) begin @(negedge clk); n++; end
        write_mem = 1'b1; index = '0; data = 8'h77;
        @(negedge clk); n++;
        write_mem = 1'b0;
        chk("wr_drop during scan", wr_drop, 1);
        wait_valid(e);
        chk("full buffer latency", n + e, DEPTH + 1);
        ack();
        push(2'd0, 0, '0, 1'b1);
        pulse(4'b0001);
        wait_valid(e);
        ack();

        // Reset mid-SCAN, with a warning strobe held high across release.
        for (int unsigned i = 0; i < DEPTH; i++) wr(i, 8'h30);
        pulse(4'b0001);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midscan rst msg_valid", msg_valid, 0);
        chk("midscan rst busy", busy, 0);
        chk("midscan rst error_count", error_count, 0);
        chk("midscan rst cmp_fail_count", cmp_fail_count, 0);
        chk("midscan rst wr_drop", wr_drop, 0);
        @(negedge clk);
        strb = 4'b0010;
        push(2'd1, 0, '0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        strb = '0;
        wait_valid(e);
        ack();
        wr(0, 8'h41);
        push(2'd0, 1, 'h41, 1'b1);
        pulse(4'b0001);
        wait_valid(e);
        ack();
        chk("warning_count after held strobe", warning_count, 1);

        // Repeat warnings: overflow only while a warning is already pending.
        push(2'd1, 0, '0, 1'b1);
        pulse(4'b0010);
        wait_valid(e);
        push(2'd1, 0, '0, 1'b1);
        pulse(4'b0010);
        chk("req_overflow after first re-request", req_overflow, 0);
        pulse(4'b0010);
        chk("req_overflow after second re-request", req_overflow, 1);
        ack();
        wait_valid(e);
        ack();
        repeat (10) @(negedge clk);
        chk("no extra warning message", msg_valid, 0);
        chk("idle after warnings", busy, 0);
        chk("warning_count", warning_count, 3);
        for (int i = 0; i < 6; i++) begin
            push(2'd1, 0, '0, 1'b1);
            pulse(4'b0010);
            wait_valid(e);
            ack();
        end
        chk("warning_count saturated", warning_count, 7);

        repeat (3) @(negedge clk);
        chk("scoreboard drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
